// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with valid/ready handshakes on issue and result.
//
// state | meaning
// IDLE  | waiting for a request, in_ready=1
// BUSY  | iterating, one bit per clock
// DONE  | result held, out_valid=1 until consumed
module muldiv_unit #(
  parameter  int XLEN  = 32,
  localparam int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state;
  logic [2:0]        op_q;
  logic              neg_q;
  logic [XLEN-1:0]   b_q;
  logic [2*XLEN-1:0] acc;
  logic [CNT_W-1:0]  cnt;

  logic              a_signed, b_signed, a_neg, b_neg, neg_in;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              div_zero, div_ovf, fast;
  logic [XLEN-1:0]   fast_res;

  assign a_signed = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
  assign b_signed = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
  assign a_neg    = a_signed & in_a[XLEN-1];
  assign b_neg    = b_signed & in_b[XLEN-1];
  assign a_mag    = a_neg ? -in_a : in_a;
  assign b_mag    = b_neg ? -in_b : in_b;
  // Remainder takes the dividend's sign; everything else the XOR of both signs.
  assign neg_in   = (op[2] && op[1]) ? a_neg : (a_neg ^ b_neg);

  assign div_zero = op[2] && (in_b == '0);
  assign div_ovf  = op[2] && !op[0] && (in_a == MIN_NEG) && (in_b == '1);
  assign fast     = div_zero || div_ovf;
  assign fast_res = div_zero ? (op[1] ? in_a : '1) : (op[1] ? '0 : in_a);

  logic [XLEN:0]     mul_hi, div_shift, div_trial;
  logic [2*XLEN-1:0] mul_next, div_next, step_next, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fin_res;
  logic              cnt_last;

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
  assign mul_hi    = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_q} : '0);
  assign mul_next  = {mul_hi, acc[XLEN-1:1]};
  assign div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
  assign div_trial = div_shift - {1'b0, b_q};
  assign div_next  = div_trial[XLEN] ? {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                     : {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
  assign step_next = op_q[2] ? div_next : mul_next;

  assign prod_fix  = neg_q ? -step_next : step_next;
  assign quo_fix   = neg_q ? -step_next[XLEN-1:0] : step_next[XLEN-1:0];
  assign rem_fix   = neg_q ? -step_next[2*XLEN-1:XLEN] : step_next[2*XLEN-1:XLEN];
  assign cnt_last  = (cnt == CNT_W'(XLEN - 1));

  always_comb begin
    fin_res = '0;
    case (op_q)
      3'b000:                 fin_res = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fin_res = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fin_res = quo_fix;
      default:                fin_res = rem_fix;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b1;
      op_q      <= '0;
      neg_q     <= 1'b0;
      b_q       <= '0;
      acc       <= '0;
      cnt       <= '0;
    end else if (flush) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_q     <= op;
            neg_q    <= neg_in;
            b_q      <= b_mag;
            acc      <= {{XLEN{1'b0}}, a_mag};
            cnt      <= '0;
            in_ready <= 1'b0;
            if (fast) begin
              result    <= fast_res;
              zero      <= (fast_res == '0);
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          acc <= step_next;
          cnt <= cnt + CNT_W'(1);
          if (cnt_last) begin
            result    <= fin_res;
            zero      <= (fin_res == '0);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases, randomized ops against
// a 64-bit arithmetic reference, backpressure, flush and mid-operation reset.
module tb_muldiv_unit;
  localparam int XLEN = 32;
  // Cycles from the accept cycle to the first cycle where out_valid is seen high.
  localparam int LAT_FAST = 1;
  localparam int LAT_BUSY = XLEN + 1;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, zero;
  logic [2:0]  op;
  logic [31:0] in_a, in_b, result;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] last_exp;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .op(op), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero)
  );

  function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ub, p;
    logic [63:0] pu;
    int          ia, ib;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ub  = longint'({32'h0, b});
    ia  = $signed(a);
    ib  = $signed(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (o)
      3'b000: begin p = sa * sb; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * ub; return p[63:32]; end
      3'b011: begin pu = {32'h0, a} * {32'h0, b}; return pu[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        return ia / ib;
      end
      3'b101: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'b110: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        return ia % ib;
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o[2] && (b == 0)) return LAT_FAST;
    if ((o == 3'b100 || o == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return LAT_FAST;
    return LAT_BUSY;
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 20);
      4: return -$urandom_range(1, 20);
      default: return $urandom;
    endcase
  endfunction

  task automatic start_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    in_valid = 1'b1; op = o; in_a = a; in_b = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0; op = 3'($urandom); in_a = $urandom; in_b = $urandom;
  endtask

  task automatic wait_result(output int cyc);
    cyc = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (out_valid) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; in_a = '0; in_b = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({in_ready, out_valid, zero} !== 3'b101 || result !== 32'h0) begin
      n_fail++;
      $display("FAIL reset: in_ready=%b out_valid=%b zero=%b result=%h, want 1 0 1 00000000",
               in_ready, out_valid, zero, result);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({in_ready, out_valid, zero} !== 3'b101 || result !== 32'h0) begin
      n_fail++;
      $display("FAIL post_reset_idle: in_ready=%b out_valid=%b zero=%b result=%h", in_ready, out_valid, zero, result);
    end
    last_exp = 32'h0;
  endtask

  typedef struct packed {
    logic [2:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
  } vec_t;

  task automatic test_directed();
    vec_t v[15];
    int   lat;
    v[0]  = '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB};
    v[1]  = '{3'b001, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
    v[2]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    v[3]  = '{3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF};
    v[4]  = '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD};
    v[5]  = '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF};
    v[6]  = '{3'b101, 32'd100,       32'd7,         32'd14};
    v[7]  = '{3'b111, 32'd100,       32'd7,         32'd2};
    v[8]  = '{3'b111, 32'd5,         32'd5,         32'd0};
    v[9]  = '{3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF};
    v[10] = '{3'b110, 32'd5,         32'd0,         32'd5};
    v[11] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    v[12] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0};
    v[13] = '{3'b100, 32'h8000_0000, 32'h0000_0002, 32'hC000_0000};
    v[14] = '{3'b000, 32'h0,         32'h1234_5678, 32'h0};
    for (int i = 0; i < 15; i++) begin
      start_op(v[i].o, v[i].a, v[i].b);
      wait_result(lat);
      n_checks++;
      if (result !== v[i].r || zero !== (v[i].r == 0)) begin
        n_fail++;
        $display("FAIL directed[%0d] result: got %h zero=%b, want %h zero=%b", i, result, zero, v[i].r, v[i].r == 0);
      end
      n_checks++;
      if (lat !== exp_lat(v[i].o, v[i].a, v[i].b)) begin
        n_fail++;
        $display("FAIL directed[%0d] latency: got %0d, want %0d", i, lat, exp_lat(v[i].o, v[i].a, v[i].b));
      end
      consume();
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL directed[%0d] handoff: in_ready=%b out_valid=%b, want 1 0", i, in_ready, out_valid);
      end
      last_exp = v[i].r;
    end
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [31:0] a, b, e;
    int          lat;
    for (int i = 0; i < 60; i++) begin
      o = 3'($urandom_range(0, 7));
      a = rand_operand();
      b = rand_operand();
      e = ref_res(o, a, b);
      start_op(o, a, b);
      wait_result(lat);
      n_checks++;
      if (result !== e || zero !== (e == 0)) begin
        n_fail++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h: got %h zero=%b, want %h", i, o, a, b, result, zero, e);
      end
      n_checks++;
      if (lat !== exp_lat(o, a, b)) begin
        n_fail++;
        $display("FAIL random[%0d] latency op=%0d: got %0d, want %0d", i, o, lat, exp_lat(o, a, b));
      end
      consume();
      last_exp = e;
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] e;
    int          lat, bad;
    e = ref_res(3'b011, 32'hDEAD_BEEF, 32'h1234_5679);
    start_op(3'b011, 32'hDEAD_BEEF, 32'h1234_5679);
    wait_result(lat);
    bad = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      if (result !== e || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
    end
    in_valid = 1'b0;
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL backpressure_hold: %0d bad cycles (result %h want %h), want 0", bad, result, e);
    end
    consume();
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== e) begin
      n_fail++;
      $display("FAIL backpressure_release: in_ready=%b out_valid=%b result=%h, want 1 0 %h", in_ready, out_valid, result, e);
    end
    last_exp = e;
  endtask

  task automatic test_flush();
    int seen, lat;
    start_op(3'b101, 32'd1000, 32'd7);
    repeat (15) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== last_exp) begin
      n_fail++;
      $display("FAIL flush_busy: in_ready=%b out_valid=%b result=%h, want 1 0 %h", in_ready, out_valid, result, last_exp);
    end
    seen = 0;
    repeat (50) begin @(negedge clk); if (out_valid) seen++; end
    n_checks++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL flush_no_valid: out_valid seen %0d cycles, want 0", seen);
    end
    // Fast-path result discarded while sitting in DONE.
    start_op(3'b101, 32'd5, 32'd0);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL flush_done: in_ready=%b out_valid=%b result=%h, want 1 0 ffffffff", in_ready, out_valid, result);
    end
    last_exp = 32'hFFFF_FFFF;
    // Flush coinciding with a request in IDLE must block the accept.
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; op = 3'b000; in_a = 32'd3; in_b = 32'd4;
    @(posedge clk);
    #1 flush = 1'b0; in_valid = 1'b0;
    seen = 0;
    repeat (40) begin @(negedge clk); if (out_valid || !in_ready) seen++; end
    n_checks++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL flush_idle_block: %0d cycles busy or valid, want 0", seen);
    end
    start_op(3'b000, 32'd3, 32'd4);
    wait_result(lat);
    n_checks++;
    if (result !== 32'd12 || zero !== 1'b0 || lat !== LAT_BUSY) begin
      n_fail++;
      $display("FAIL flush_recover: result=%h zero=%b lat=%0d, want 0000000c 0 %0d", result, zero, lat, LAT_BUSY);
    end
    consume();
    last_exp = 32'd12;
  endtask

  task automatic test_reset_mid();
    int seen, lat;
    start_op(3'b100, 32'd12345, 32'd7);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, out_valid, zero} !== 3'b101 || result !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid: in_ready=%b out_valid=%b zero=%b result=%h, want 1 0 1 00000000",
               in_ready, out_valid, zero, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (50) begin @(negedge clk); if (out_valid) seen++; end
    n_checks++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL reset_mid_no_valid: out_valid seen %0d cycles, want 0", seen);
    end
    start_op(3'b000, 32'd3, 32'd4);
    wait_result(lat);
    n_checks++;
    if (result !== 32'd12 || zero !== 1'b0 || lat !== LAT_BUSY) begin
      n_fail++;
      $display("FAIL reset_recover: result=%h zero=%b lat=%0d, want 0000000c 0 %0d", result, zero, lat, LAT_BUSY);
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks done", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
